// File: rtl/sensor_cfg_seq.sv
// Plays a parameter-held register table to the SCCB master; delay entries, NACK => FAIL (CFG_SEQ_RETRY_EN: re-issue up to RETRY_CNT times).
// Command on valid/ready, held stable while ready is low; first command 2 cycles after start, 1 FETCH cycle between writes.
module sensor_cfg_seq #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int MODE_CNT   = 4,
    parameter int MAX_OPS    = 64,
    parameter bit [MODE_CNT-1:0][MAX_OPS-1:0][ADDR_W+DATA_W-1:0] MODE_ROM = '0,
    parameter int OPS_CNT [MODE_CNT-1:0] = '{default: 0},
    parameter bit [ADDR_W-1:0] DELAY_ADDR = '1,
    parameter int DELAY_UNIT = 1000,
    parameter int RETRY_CNT  = 3,
    localparam int MODE_W    = (MODE_CNT > 1) ? $clog2(MODE_CNT) : 1,
    localparam int IDX_W     = $clog2(MAX_OPS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [DATA_W-1:0] cmd_data_o,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    input  logic              wr_done_i,
    input  logic              wr_err_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [IDX_W-1:0]  op_idx_o
);
    localparam int EIDX_W = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;
    localparam int CNT_W  = DATA_W + $clog2(DELAY_UNIT + 1);
    localparam int RTRY_W = (RETRY_CNT > 0) ? $clog2(RETRY_CNT + 1) : 1;

`ifdef CFG_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT_WR, S_DELAY, S_FINISH, S_FAIL
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [MODE_W-1:0]         r_mode;
    logic [IDX_W-1:0]          r_idx;
    logic [ADDR_W-1:0]         r_addr;
    logic [DATA_W-1:0]         r_data;
    logic [CNT_W-1:0]          r_cnt;
    logic [RTRY_W-1:0]         r_retry;
    logic                      r_done;
    logic                      r_err;
    logic [EIDX_W-1:0]         w_eidx;
    logic [ADDR_W+DATA_W-1:0]  w_entry;
    logic                      w_mode_bad;
    logic                      w_tbl_end;
    logic                      w_is_delay;
    logic                      w_retry;
    logic                      w_busy;
    logic                      w_valid;

    // Index reaches MAX_OPS only when the table is exhausted, so the truncated ROM read is never used then.
    assign w_eidx     = r_idx[EIDX_W-1:0];
    assign w_entry    = MODE_ROM[r_mode][w_eidx];
    assign w_mode_bad = 32'(mode_i) >= MODE_CNT;
    assign w_tbl_end  = 32'(r_idx) == OPS_CNT[r_mode];
    assign w_is_delay = w_entry[ADDR_W+DATA_W-1:DATA_W] == DELAY_ADDR;
    assign w_retry    = RETRY_EN && (r_retry < RTRY_W'(RETRY_CNT));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_next = w_mode_bad ? S_FAIL : S_FETCH;
            S_FETCH: begin
                if (w_tbl_end)       w_next = S_FINISH;
                else if (w_is_delay) w_next = S_DELAY;
                else                 w_next = S_ISSUE;
            end
            S_ISSUE:   if (cmd_ready_i) w_next = S_WAIT_WR;
            S_WAIT_WR: if (wr_done_i) w_next = !wr_err_i ? S_FETCH : (w_retry ? S_ISSUE : S_FAIL);
            S_DELAY:   if (r_cnt == '0) w_next = S_FETCH;
            S_FINISH:  w_next = S_IDLE;
            S_FAIL:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = r_state != S_IDLE;
        w_valid = r_state == S_ISSUE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_mode  <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= r_state == S_FINISH;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_mode  <= mode_i;
                    r_idx   <= '0;
                    r_retry <= '0;
                    r_err   <= 1'b0;
                end
                S_FETCH: if (!w_tbl_end) begin
                    r_addr <= w_entry[ADDR_W+DATA_W-1:DATA_W];
                    r_data <= w_entry[DATA_W-1:0];
                    r_cnt  <= CNT_W'(w_entry[DATA_W-1:0]) * CNT_W'(DELAY_UNIT);
                end
                S_WAIT_WR: if (wr_done_i) begin
                    if (!wr_err_i) begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_retry <= '0;
                    end else if (w_retry) begin
                        r_retry <= r_retry + RTRY_W'(1);
                    end
                end
                S_DELAY: begin
                    if (r_cnt == '0) r_idx <= r_idx + IDX_W'(1);
                    else             r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FAIL:  r_err <= 1'b1;
                default: ;
            endcase
        end
    end

    assign cmd_addr_o  = r_addr;
    assign cmd_data_o  = r_data;
    assign cmd_valid_o = w_valid;
    assign busy_o      = w_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign op_idx_o    = r_idx;
endmodule
